pm_bus_dma: RTL and testbench
=============================

# pm_bus_dma

Word-copy bus initiator on the ibex data bus: a programmed number of 32-bit words is read from a source address and written to a destination address, one transaction at a time. It drives the master side of the same req/gnt/rvalid protocol that the pixel-matrix controller answers as a slave. Typical use is draining the PMC DOUT_0/DOUT_1 registers, with fixed source and incrementing destination, into data RAM without CPU load/store loops. It sits beside the core as a second data-bus master ahead of the interconnect arbiter.

## Interface
Parameters
- LEN_W, 16, width of the word-count input and the internal counter.

Ports
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset, sampled on the rising edge of clk.
- start  in  1  one-cycle request to begin a copy; ignored while busy.
- src_addr  in  32  first source byte address; bits [1:0] are ignored and treated as 0.
- dst_addr  in  32  first destination byte address; bits [1:0] are ignored and treated as 0.
- len  in  LEN_W  number of words to copy.
- src_inc  in  1  1: source advances by 4 per word; 0: source address is fixed.
- dst_inc  in  1  1: destination advances by 4 per word; 0: destination address is fixed.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse when a copy completes or aborts.
- error  out  1  sticky; set on abort, cleared by the next accepted start.
- req  out  1  bus request.
- gnt  in  1  bus grant.
- rvalid  in  1  response valid.
- we  out  1  write enable.
- be  out  4  byte enables; always 4'b1111.
- addr  out  32  bus address; bits [1:0] always 0.
- wdata  out  32  write data.
- rdata  in  32  read data.
- err  in  1  response error, valid with rvalid.

## Operation
- start, src_addr, dst_addr, len, src_inc and dst_inc are sampled together in IDLE when start=1. The address registers, the count register and the inc flags load from them.
- FSM states: IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, FIN.
- IDLE + start: if len==0, go to FIN; otherwise go to RD_REQ.
- RD_REQ: req=1, we=0, addr=src.
  - On gnt, go to RD_WAIT.
- RD_WAIT: req=0.
  - On rvalid, capture rdata into the data register and go to WR_REQ.
- WR_REQ: req=1, we=1, addr=dst, wdata=data register.
  - On gnt, go to WR_WAIT.
- WR_WAIT: req=0.
  - On rvalid, decrement the count.
  - If src_inc, src += 4; if dst_inc, dst += 4. Addition is mod 2^32 (wraps past 0xFFFF_FFFC to 0).
  - If the count becomes 0, go to FIN; otherwise go to RD_REQ.
- FIN: done=1 for one cycle, then go to IDLE.
- Exactly one outstanding transaction at any time. rvalid is honoured only in the *_WAIT states and ignored elsewhere.
- start during busy: no effect.

## Timing
- Reset values: req=0, we=0, be=4'b1111, addr=0, wdata=0, busy=0, done=0, error=0, state IDLE.
- All outputs are registered except be, which is constant.
- req, we, addr and wdata are held stable while in a *_REQ state until gnt. gnt in the same cycle that req rises is a legal grant.
- The bus is idle for one cycle between a response and the next request.
- Per word with zero-wait gnt and rvalid one cycle after gnt: 4 cycles.
  - Copy of N words with N≥1: done is asserted 4N+2 cycles after the start cycle.
  - len==0: done is asserted 2 cycles after start, with no bus activity.
- busy falls in the same cycle that done is high.
- rst asserted mid-copy: the next edge returns every output to its reset value. No completing write is issued. A pending response from the interconnect is ignored.

## Configuration
- PM_BUS_DMA_ERR_ABORT_EN defined:
  - err=1 together with rvalid in RD_WAIT or WR_WAIT sets error and goes directly to FIN.
  - No further transactions are issued; the remaining count is discarded.
- PM_BUS_DMA_ERR_ABORT_EN undefined:
  - err is ignored and the copy runs to completion.
  - The error output is tied to 0.

## Test plan
- len=3, src=0x1000_0000 inc, dst=0x0000_2000 inc, zero-wait slave returning 0xA0,0xA1,0xA2: required response is writes of 0xA0/0xA1/0xA2 to 0x2000/0x2004/0x2008, done 14 cycles after start, error=0.
- len=2, src fixed at the PMC DOUT_0 address, dst inc from 0x100, slave returning 0x5 then 0x6: required response is two reads of the same address and writes to 0x100/0x104.
- gnt withheld for 5 cycles on the first read: req/addr/we are stable throughout and done is delayed by exactly 5 cycles. A second start pulsed while busy changes nothing.
- len=0: required response is done 2 cycles after start, req never asserted.
- dst=0xFFFF_FFFC inc, len=2: second write goes to 0x0000_0000. With the macro defined, err on the first write response gives error=1, done, and no further req.
- rst pulsed while in WR_REQ: next cycle req=0, busy=0, state IDLE; a new start then runs normally.

Source files
------------

// File: rtl/pm_bus_dma.sv
// Word-copy bus master: reads len words from src, writes them to dst, one transaction at a time.
// Define PM_BUS_DMA_ERR_ABORT_EN to abort a copy on a bus error response.
module pm_bus_dma #(
    parameter int LEN_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [31:0]      src_addr,
    input  logic [31:0]      dst_addr,
    input  logic [LEN_W-1:0] len,
    input  logic             src_inc,
    input  logic             dst_inc,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic             req,
    input  logic             gnt,
    input  logic             rvalid,
    output logic             we,
    output logic [3:0]       be,
    output logic [31:0]      addr,
    output logic [31:0]      wdata,
    input  logic [31:0]      rdata,
    input  logic             err
);

    typedef enum logic [2:0] {
        IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, FIN
    } state_t;

    state_t           state, state_n;
    logic [31:0]      src, src_n, src_nx;
    logic [31:0]      dst, dst_n, dst_nx;
    logic [LEN_W-1:0] cnt, cnt_n;
    logic             sinc, sinc_n;
    logic             dinc, dinc_n;
    logic             req_n, we_n, busy_n, done_n, error_n;
    logic [31:0]      addr_n, wdata_n;
    logic             abort;
    logic             unused;

    assign be     = 4'b1111;
    assign unused = ^{err, src_addr[1:0], dst_addr[1:0]};

`ifdef PM_BUS_DMA_ERR_ABORT_EN
    assign abort = rvalid & err;
`else
    assign abort = 1'b0;
`endif

    assign src_nx = sinc ? src + 32'd4 : src;
    assign dst_nx = dinc ? dst + 32'd4 : dst;

    always_comb begin
        state_n = state;
        src_n   = src;
        dst_n   = dst;
        cnt_n   = cnt;
        sinc_n  = sinc;
        dinc_n  = dinc;
        req_n   = req;
        we_n    = we;
        addr_n  = addr;
        wdata_n = wdata;
        busy_n  = busy;
        done_n  = 1'b0;
        error_n = error;
        unique case (state)
            IDLE: begin
                if (start) begin
                    src_n   = {src_addr[31:2], 2'b00};
                    dst_n   = {dst_addr[31:2], 2'b00};
                    cnt_n   = len;
                    sinc_n  = src_inc;
                    dinc_n  = dst_inc;
                    busy_n  = 1'b1;
                    error_n = 1'b0;
                    if (len == '0) begin
                        state_n = FIN;
                    end else begin
                        state_n = RD_REQ;
                        req_n   = 1'b1;
                        we_n    = 1'b0;
                        addr_n  = {src_addr[31:2], 2'b00};
                    end
                end
            end
            RD_REQ: begin
                if (gnt) begin
                    state_n = RD_WAIT;
                    req_n   = 1'b0;
                end
            end
            RD_WAIT: begin
                if (rvalid) begin
                    if (abort) begin
                        state_n = FIN;
                        error_n = 1'b1;
                    end else begin
                        state_n = WR_REQ;
                        wdata_n = rdata;
                        req_n   = 1'b1;
                        we_n    = 1'b1;
                        addr_n  = dst;
                    end
                end
            end
            WR_REQ: begin
                if (gnt) begin
                    state_n = WR_WAIT;
                    req_n   = 1'b0;
                    we_n    = 1'b0;
                end
            end
            WR_WAIT: begin
                if (rvalid) begin
                    if (abort) begin
                        state_n = FIN;
                        error_n = 1'b1;
                    end else begin
                        cnt_n = cnt - LEN_W'(1);
                        src_n = src_nx;
                        dst_n = dst_nx;
                        if (cnt == LEN_W'(1)) begin
                            state_n = FIN;
                        end else begin
                            state_n = RD_REQ;
                            req_n   = 1'b1;
                            we_n    = 1'b0;
                            addr_n  = src_nx;
                        end
                    end
                end
            end
            FIN: begin
                state_n = IDLE;
                done_n  = 1'b1;
                busy_n  = 1'b0;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            src   <= '0;
            dst   <= '0;
            cnt   <= '0;
            sinc  <= 1'b0;
            dinc  <= 1'b0;
            req   <= 1'b0;
            we    <= 1'b0;
            addr  <= '0;
            wdata <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            error <= 1'b0;
        end else begin
            state <= state_n;
            src   <= src_n;
            dst   <= dst_n;
            cnt   <= cnt_n;
            sinc  <= sinc_n;
            dinc  <= dinc_n;
            req   <= req_n;
            we    <= we_n;
            addr  <= addr_n;
            wdata <= wdata_n;
            busy  <= busy_n;
            done  <= done_n;
            error <= error_n;
        end
    end

endmodule

// File: tb/tb_pm_bus_dma.sv
// Directed testbench for pm_bus_dma with a cycle-driven zero-wait bus slave.
module tb_pm_bus_dma;

    logic        clk = 1'b0;
    logic        rst, start, src_inc, dst_inc;
    logic [31:0] src_addr, dst_addr, rdata, addr, wdata;
    logic [15:0] len;
    logic        gnt, rvalid, err;
    logic        busy, done, error, req, we;
    logic [3:0]  be;

    int tests = 0;
    int fails = 0;

    logic [31:0] rd_vals [8];
    logic [31:0] rd_addr [8];
    logic [31:0] wr_addr [8];
    logic [31:0] wr_data [8];
    int          n_rd, n_wr;
    bit          stall_ok, req_seen, busy_ok;

    always #5 clk = ~clk;

    pm_bus_dma #(.LEN_W(16)) dut (
        .clk(clk), .rst(rst), .start(start),
        .src_addr(src_addr), .dst_addr(dst_addr), .len(len),
        .src_inc(src_inc), .dst_inc(dst_inc),
        .busy(busy), .done(done), .error(error),
        .req(req), .gnt(gnt), .rvalid(rvalid), .we(we), .be(be),
        .addr(addr), .wdata(wdata), .rdata(rdata), .err(err)
    );

    // Starts a copy and plays the slave until done; lat is cycles from start to done, -1 on timeout.
    task automatic run_copy(input logic [31:0] s, input logic [31:0] d,
                            input logic [15:0] l, input logic si, input logic di,
                            input int stall, input int err_idx, input int busy_cyc,
                            output int lat);
        int          stall_left;
        bit          pend, pend_wr;
        logic [31:0] s_addr;
        logic        s_we;
        n_rd = 0; n_wr = 0; lat = -1;
        stall_ok = 1; req_seen = 0; busy_ok = 1;
        s_addr = '0; s_we = 1'b0;
        @(posedge clk); #1;
        start = 1; src_addr = s; dst_addr = d; len = l;
        src_inc = si; dst_inc = di;
        gnt = 0; rvalid = 0; err = 0;
        stall_left = stall; pend = 0; pend_wr = 0;
        for (int cyc = 1; cyc <= 200; cyc++) begin
            @(posedge clk); #1;
            start = 0;
            if (cyc == busy_cyc) begin
                start = 1; src_addr = 32'hDEAD_0000;
                dst_addr = 32'hBEEF_0000; len = 16'd7;
            end
            gnt = 0; rvalid = 0; err = 0; rdata = '0;
            if (done) begin
                if (busy !== 1'b0) busy_ok = 0;
                lat = cyc;
                break;
            end
            if (busy !== 1'b1) busy_ok = 0;
            if (pend) begin
                rvalid = 1; pend = 0;
                if (pend_wr) err = (n_wr - 1 == err_idx);
                else rdata = rd_vals[n_rd - 1];
            end
            if (req) begin
                req_seen = 1;
                if (stall_left > 0) begin
                    if (stall_left == stall) begin
                        s_addr = addr; s_we = we;
                    end else if (addr !== s_addr || we !== s_we) begin
                        stall_ok = 0;
                    end
                    stall_left--;
                end else if (n_rd < 8 && n_wr < 8) begin
                    if (stall > 0 && n_rd == 0 && (addr !== s_addr || we !== s_we))
                        stall_ok = 0;
                    gnt = 1; pend = 1; pend_wr = we;
                    if (we) begin
                        wr_addr[n_wr] = addr; wr_data[n_wr] = wdata; n_wr++;
                    end else begin
                        rd_addr[n_rd] = addr; n_rd++;
                    end
                end
            end
        end
        gnt = 0; rvalid = 0; err = 0; start = 0;
    endtask

    task automatic test_reset;
        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if ({req, we, busy, done, error} !== 5'b0) begin
            fails++;
            $display("FAIL reset_ctl got %b want 00000", {req, we, busy, done, error});
        end
        tests++;
        if (be !== 4'hF) begin
            fails++; $display("FAIL reset_be got %h want f", be);
        end
        tests++;
        if (addr !== 32'h0 || wdata !== 32'h0) begin
            fails++; $display("FAIL reset_bus got %h/%h want 0/0", addr, wdata);
        end
        rst = 0;
    endtask

    task automatic test_basic;
        int lat;
        rd_vals[0] = 32'hA0; rd_vals[1] = 32'hA1; rd_vals[2] = 32'hA2;
        run_copy(32'h1000_0000, 32'h0000_2000, 16'd3, 1, 1, 0, -1, -1, lat);
        tests++;
        if (lat != 14) begin
            fails++; $display("FAIL basic_latency got %0d want 14", lat);
        end
        tests++;
        if (n_wr != 3 || n_rd != 3) begin
            fails++; $display("FAIL basic_count got %0d/%0d want 3/3", n_rd, n_wr);
        end
        for (int i = 0; i < 3; i++) begin
            tests++;
            if (wr_addr[i] !== 32'h2000 + 32'(4 * i) || wr_data[i] !== 32'hA0 + 32'(i)) begin
                fails++;
                $display("FAIL basic_wr%0d got %h:%h want %h:%h", i, wr_addr[i], wr_data[i],
                         32'h2000 + 32'(4 * i), 32'hA0 + 32'(i));
            end
            tests++;
            if (rd_addr[i] !== 32'h1000_0000 + 32'(4 * i)) begin
                fails++;
                $display("FAIL basic_rd%0d got %h want %h", i, rd_addr[i],
                         32'h1000_0000 + 32'(4 * i));
            end
        end
        tests++;
        if (error !== 1'b0 || !busy_ok) begin
            fails++; $display("FAIL basic_flags got err=%b busy_ok=%0d want 0/1", error, busy_ok);
        end
    endtask

    task automatic test_fixed_src;
        int lat;
        rd_vals[0] = 32'h5; rd_vals[1] = 32'h6;
        run_copy(32'h8000_0010, 32'h0000_0100, 16'd2, 0, 1, 0, -1, -1, lat);
        tests++;
        if (rd_addr[0] !== 32'h8000_0010 || rd_addr[1] !== 32'h8000_0010 || n_rd != 2) begin
            fails++;
            $display("FAIL fixed_rd got %h,%h n=%0d want 80000010 x2", rd_addr[0], rd_addr[1], n_rd);
        end
        tests++;
        if (wr_addr[0] !== 32'h100 || wr_addr[1] !== 32'h104 ||
            wr_data[0] !== 32'h5 || wr_data[1] !== 32'h6) begin
            fails++;
            $display("FAIL fixed_wr got %h:%h %h:%h want 100:5 104:6",
                     wr_addr[0], wr_data[0], wr_addr[1], wr_data[1]);
        end
        tests++;
        if (lat != 10) begin
            fails++; $display("FAIL fixed_latency got %0d want 10", lat);
        end
    endtask

    task automatic test_stall_busy_start;
        int lat;
        rd_vals[0] = 32'h11; rd_vals[1] = 32'h22;
        run_copy(32'h3000, 32'h4000, 16'd2, 1, 1, 5, -1, 3, lat);
        tests++;
        if (lat != 15) begin
            fails++; $display("FAIL stall_latency got %0d want 15", lat);
        end
        tests++;
        if (!stall_ok) begin
            fails++; $display("FAIL stall_stable got unstable want stable");
        end
        tests++;
        if (n_wr != 2 || wr_addr[0] !== 32'h4000 || wr_addr[1] !== 32'h4004 ||
            wr_data[0] !== 32'h11 || wr_data[1] !== 32'h22) begin
            fails++;
            $display("FAIL stall_wr got n=%0d %h:%h %h:%h want 4000:11 4004:22",
                     n_wr, wr_addr[0], wr_data[0], wr_addr[1], wr_data[1]);
        end
    endtask

    task automatic test_len_zero;
        int lat;
        run_copy(32'h10, 32'h20, 16'd0, 1, 1, 0, -1, -1, lat);
        tests++;
        if (lat != 2) begin
            fails++; $display("FAIL len0_latency got %0d want 2", lat);
        end
        tests++;
        if (req_seen || !busy_ok) begin
            fails++; $display("FAIL len0_bus got req_seen=%0d busy_ok=%0d want 0/1", req_seen, busy_ok);
        end
    endtask

    task automatic test_wrap;
        int lat;
        rd_vals[0] = 32'h1; rd_vals[1] = 32'h2;
        run_copy(32'h20, 32'hFFFF_FFFF, 16'd2, 1, 1, 0, -1, -1, lat);
        tests++;
        if (wr_addr[0] !== 32'hFFFF_FFFC || wr_addr[1] !== 32'h0 || n_wr != 2) begin
            fails++;
            $display("FAIL wrap_addr got %h,%h n=%0d want fffffffc,0", wr_addr[0], wr_addr[1], n_wr);
        end
        tests++;
        if (rd_addr[1] !== 32'h24 || lat != 10) begin
            fails++; $display("FAIL wrap_rd got %h lat=%0d want 24 lat=10", rd_addr[1], lat);
        end
    endtask

    task automatic test_err;
        int lat;
        int reqs;
        rd_vals[0] = 32'hC0; rd_vals[1] = 32'hC1; rd_vals[2] = 32'hC2;
        run_copy(32'h900, 32'h5000, 16'd3, 1, 1, 0, 0, -1, lat);
        reqs = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (req) reqs++;
        end
`ifdef PM_BUS_DMA_ERR_ABORT_EN
        tests++;
        if (lat != 6 || n_wr != 1 || n_rd != 1) begin
            fails++; $display("FAIL err_abort got lat=%0d rd=%0d wr=%0d want 6/1/1", lat, n_rd, n_wr);
        end
        tests++;
        if (error !== 1'b1 || reqs != 0) begin
            fails++; $display("FAIL err_flag got err=%b reqs=%0d want 1/0", error, reqs);
        end
        rd_vals[0] = 32'hE1;
        run_copy(32'h900, 32'h6000, 16'd1, 1, 1, 0, -1, -1, lat);
        tests++;
        if (error !== 1'b0 || lat != 6 || wr_data[0] !== 32'hE1) begin
            fails++;
            $display("FAIL err_clear got err=%b lat=%0d d=%h want 0/6/e1", error, lat, wr_data[0]);
        end
`else
        tests++;
        if (lat != 14 || n_wr != 3 || wr_addr[2] !== 32'h5008 || wr_data[2] !== 32'hC2) begin
            fails++;
            $display("FAIL err_ignored got lat=%0d wr=%0d %h:%h want 14/3 5008:c2",
                     lat, n_wr, wr_addr[2], wr_data[2]);
        end
        tests++;
        if (error !== 1'b0 || reqs != 0) begin
            fails++; $display("FAIL err_flag got err=%b reqs=%0d want 0/0", error, reqs);
        end
`endif
    endtask

    task automatic test_reset_mid;
        int  lat;
        bit  pend, got_wr;
        pend = 0; got_wr = 0;
        @(posedge clk); #1;
        start = 1; src_addr = 32'h600; dst_addr = 32'h700; len = 16'd2;
        src_inc = 1; dst_inc = 1;
        for (int c = 0; c < 20 && !got_wr; c++) begin
            @(posedge clk); #1;
            start = 0; gnt = 0; rvalid = 0; rdata = '0;
            if (pend) begin
                rvalid = 1; rdata = 32'h77; pend = 0;
            end
            if (req && we) got_wr = 1;
            else if (req) begin
                gnt = 1; pend = 1;
            end
        end
        tests++;
        if (!got_wr || wdata !== 32'h77) begin
            fails++; $display("FAIL rstmid_reach got wr=%0d d=%h want 1/77", got_wr, wdata);
        end
        rst = 1;
        @(posedge clk); #1;
        rst = 0; rvalid = 1;
        tests++;
        if ({req, we, busy, done, error} !== 5'b0 || addr !== 32'h0 || wdata !== 32'h0) begin
            fails++;
            $display("FAIL rstmid_out got %b %h %h want 00000 0 0", {req, we, busy, done, error}, addr, wdata);
        end
        @(posedge clk); #1;
        rvalid = 0;
        tests++;
        if (req !== 1'b0 || busy !== 1'b0) begin
            fails++; $display("FAIL rstmid_idle got req=%b busy=%b want 0/0", req, busy);
        end
        rd_vals[0] = 32'h9;
        run_copy(32'h40, 32'h50, 16'd1, 1, 1, 0, -1, -1, lat);
        tests++;
        if (lat != 6 || n_wr != 1 || wr_addr[0] !== 32'h50 || wr_data[0] !== 32'h9) begin
            fails++;
            $display("FAIL rstmid_restart got lat=%0d wr=%0d %h:%h want 6/1 50:9",
                     lat, n_wr, wr_addr[0], wr_data[0]);
        end
    endtask

    initial begin
        rst = 1; start = 0; src_addr = '0; dst_addr = '0; len = '0;
        src_inc = 0; dst_inc = 0; gnt = 0; rvalid = 0; rdata = '0; err = 0;
        test_reset();
        test_basic();
        test_fixed_src();
        test_stall_busy_start();
        test_len_zero();
        test_wrap();
        test_err();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
